ringbuffer_uart_tx: RTL and testbench

Drain-side companion to the team's 4-deep ring buffer. It pops bytes through the buffer's `rd_en`/`data_out`/`empty` read port and serializes each one as an asynchronous UART-style frame on `tx`. The frame is a start bit, then the data LSB-first, then optional even parity, then stop bits. The block sits between the ring buffer's read side and the chip-level serial pin.

---
 rtl/ringbuffer_uart_tx.sv | 158 +++++++++++++++
 tb/tb_ringbuffer_uart_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ringbuffer_uart_tx.sv
// ringbuffer_uart_tx: pops bytes from a 4-deep ring buffer read port and
// serializes each as an async frame: start, data LSB-first, optional even
// parity, then STOP_BITS stop bits.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   enable               permits starting new frames
//   fifo_empty/fifo_data ring buffer empty flag and data_out
//   fifo_rd_en           one-cycle pop request (registered)
//   tx                   serial line, idles high (registered)
//   busy                 high from pop request through last stop bit
//   frame_done           one-cycle pulse after the last stop bit
module ringbuffer_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bit;

  logic                  baud_done;
  logic [DATA_WIDTH-1:0] shift_nxt;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign shift_nxt = shift_reg >> 1;

  // tx is updated on the same edge as the state so the line changes exactly
  // at each bit boundary; the next bit is taken from the pre-shifted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state      <= REQ;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        // ring buffer presents the popped word at the end of this cycle
        REQ: state <= LOAD;
        LOAD: begin
          shift_reg  <= fifo_data;
          parity_bit <= ^fifo_data;
          bit_cnt    <= '0;
          baud_cnt   <= '0;
          tx         <= 1'b0;
          state      <= START;
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt  <= '0;
            shift_reg <= shift_nxt;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_nxt[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        // bit_cnt is reused to count stop-bit periods
        STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt    <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ringbuffer_uart_tx.sv
// Bench for ringbuffer_uart_tx: two instances (8N1 and 8E2, 4 clocks/bit),
// each fed by a small ring-buffer model; bytes are queued as expected
// frames when written and compared when decoded from tx.
module tb_ringbuffer_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, en1;
  logic       empty0 = 1'b1, empty1 = 1'b1;
  logic [7:0] dout0 = 8'h00, dout1 = 8'h00;
  logic       rd0, rd1, tx0, tx1, busy0, busy1, fd0, fd1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rdcnt0   = 0;
  int rd_bad   = 0;
  int frames0  = 0;
  int frames1  = 0;

  logic [7:0]  fq0[$], fq1[$];
  logic [7:0]  exp0[$], exp1[$];
  int          starts0[$], dones0[$], starts1[$], dones1[$];
  logic [15:0] last_obs0, last_obs1;

  always #5 clk = ~clk;

  ringbuffer_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en0), .fifo_empty(empty0), .fifo_data(dout0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_done(fd0));

  ringbuffer_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fifo_empty(empty1), .fifo_data(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1));

  always @(posedge clk) cyc <= cyc + 1;

  // ring buffer models: data_out updates on the pop edge, empty lags a cycle
  always @(posedge clk) begin
    if (rd0 && fq0.size() > 0) dout0 <= fq0.pop_front();
    empty0 <= (fq0.size() == 0);
    if (rd1 && fq1.size() > 0) dout1 <= fq1.pop_front();
    empty1 <= (fq1.size() == 0);
  end

  always @(negedge clk) begin
    if (rd0) begin
      rdcnt0 = rdcnt0 + 1;
      if (empty0) rd_bad = rd_bad + 1;
    end
    if (rd1 && empty1) rd_bad = rd_bad + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx0 : tx1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_fd(input int sel);
    return (sel == 0) ? fd0 : fd1;
  endfunction

  // expected line bits, index = bit period within the frame
  function automatic logic [15:0] build(input int sel, input logic [7:0] b);
    if (sel == 0) return {6'b0, 1'b1, b, 1'b0};
    return {4'b0, 2'b11, ^b, b, 1'b0};
  endfunction

  task automatic push(input int sel, input logic [7:0] b);
    if (sel == 0) begin fq0.push_back(b); exp0.push_back(b); end
    else begin fq1.push_back(b); exp1.push_back(b); end
  endtask

  // decodes frames on one tx line; a reset mid-frame discards the frame
  task automatic monitor(input int sel);
    int          nb;
    logic [7:0]  b;
    logic [15:0] exp_v, obs_v;
    bit          ok, abort;
    nb = (sel == 1) ? 12 : 10;
    forever begin
      @(negedge clk);
      if (rst_n && get_tx(sel) == 1'b0) begin
        if (sel == 0) starts0.push_back(cyc); else starts1.push_back(cyc);
        b = 8'h00;
        if (sel == 0 && exp0.size() > 0) b = exp0.pop_front();
        else if (sel == 1 && exp1.size() > 0) b = exp1.pop_front();
        else check_eq("unexpected_frame", 1, 0);
        exp_v = build(sel, b);
        obs_v = '0;
        ok    = 1'b1;
        abort = 1'b0;
        for (int c = 0; c < nb * int'(CPB) && !abort; c++) begin
          if (c > 0) @(negedge clk);
          if (!rst_n) abort = 1'b1;
          else begin
            if (get_tx(sel) !== exp_v[c / CPB]) ok = 1'b0;
            if (c % CPB == 2) obs_v[c / CPB] = get_tx(sel);
            if (get_busy(sel) !== 1'b1 || get_fd(sel) !== 1'b0) ok = 1'b0;
          end
        end
        if (!abort) begin
          @(negedge clk);
          if (rst_n) begin
            check_eq(sel == 0 ? "frame_bits0" : "frame_bits1", 32'(obs_v), 32'(exp_v));
            check_eq("bits_held_busy", 32'(ok), 1);
            check_eq("frame_done_pulse", 32'(get_fd(sel)), 1);
            check_eq("busy_drop", 32'(get_busy(sel)), 0);
            if (sel == 0) begin
              last_obs0 = obs_v; dones0.push_back(cyc); frames0 = frames0 + 1;
            end else begin
              last_obs1 = obs_v; dones1.push_back(cyc); frames1 = frames1 + 1;
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_frames(input int sel, input int target, input int budget);
    int n = 0;
    while (((sel == 0) ? frames0 : frames1) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (((sel == 0) ? frames0 : frames1) < target) check_eq("frame_timeout", 0, 1);
  endtask

  task automatic wait_starts0(input int target, input int budget);
    int n = 0;
    while (starts0.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (starts0.size() < target) check_eq("start_timeout", 0, 1);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    en0   = 1'b0;
    en1   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx0), 1);
    check_eq("rst_rd_en", 32'(rd0), 0);
    check_eq("rst_busy", 32'(busy0), 0);
    check_eq("rst_frame_done", 32'(fd0), 0);
    check_eq("rst_tx_p", 32'(tx1), 1);
    rst_n = 1'b1;

    // empty buffer with enable high: nothing may move
    en0 = 1'b1; en1 = 1'b1; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd0 || rd1 || !tx0 || !tx1 || busy0 || busy1) bad++;
    end
    check_eq("idle_when_empty", 32'(bad), 0);

    // data present but disabled
    en0 = 1'b0; en1 = 1'b0; bad = 0;
    push(0, 8'hA5);
    repeat (50) begin
      @(negedge clk);
      if (rd0 || !tx0 || busy0) bad++;
    end
    check_eq("idle_when_disabled", 32'(bad), 0);

    // single byte
    en0 = 1'b1;
    wait_frames(0, 1, 200);
    check_eq("a5_line_bits", 32'(last_obs0), 32'h34A);
    check_eq("a5_rd_pulses", 32'(rdcnt0), 1);
    if (dones0.size() > 0) check_eq("a5_frame_len", 32'(dones0[0] - starts0[0]), 40);

    // back-to-back
    push(0, 8'h01);
    push(0, 8'h80);
    wait_frames(0, 3, 400);
    check_eq("b2b_rd_pulses", 32'(rdcnt0), 3);
    if (dones0.size() > 2) begin
      check_eq("b2b_gap", 32'(starts0[2] - dones0[1]), 3);
      check_eq("b2b_len", 32'(dones0[2] - starts0[2]), 40);
    end

    // enable dropped mid-frame with three bytes queued
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    wait_starts0(4, 100);
    repeat (12) @(negedge clk);
    en0 = 1'b0;
    wait_frames(0, 4, 200);
    repeat (100) @(negedge clk);
    check_eq("drop_rd_pulses", 32'(rdcnt0), 4);
    check_eq("drop_left_in_fifo", 32'(fq0.size()), 2);
    check_eq("drop_frames", 32'(frames0), 4);
    en0 = 1'b1;
    wait_frames(0, 6, 400);
    check_eq("resume_rd_pulses", 32'(rdcnt0), 6);
    check_eq("resume_fifo_drained", 32'(fq0.size()), 0);

    // parity + two stop bits
    push(1, 8'h07);
    en1 = 1'b1;
    wait_frames(1, 1, 300);
    check_eq("par_line_bits", 32'(last_obs1), 32'hE0E);
    check_eq("par_bit", 32'(last_obs1[9]), 1);
    if (dones1.size() > 0) check_eq("par_frame_len", 32'(dones1[0] - starts1[0]), 48);
    en1 = 1'b0;

    // reset during DATA
    push(0, 8'h5A);
    push(0, 8'hC3);
    wait_starts0(7, 100);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx", 32'(tx0), 1);
    check_eq("midrst_busy", 32'(busy0), 0);
    check_eq("midrst_rd_en", 32'(rd0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frames(0, 7, 400);
    check_eq("post_rst_line_bits", 32'(last_obs0), 32'h386);
    check_eq("post_rst_rd_pulses", 32'(rdcnt0), 8);
    check_eq("post_rst_queue", 32'(exp0.size()), 0);

    repeat (10) @(negedge clk);
    check_eq("no_pop_while_empty", 32'(rd_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
